element_delay_tracker: RTL and testbench

- Consumes the per-element increment terms K_n (positive-side and negative-side) produced by the increment-term calculator.
- Turns them into integer sample delays for both halves of the array: d_{n+1}^2 = d_n^2 + K_n, evaluated as a running integer square root with one step per cycle and no multiplier.
- Emits element 0 (the reference delay), then elements 1..N_TERMS, per side, over a valid/ack handshake to the delay-sequencer stage downstream.

---
 rtl/element_delay_tracker.sv | 213 +++++++++++++++++++++
 tb/tb_element_delay_tracker.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/element_delay_tracker.sv
// Per-element delay tracker: turns a stream of signed increment terms K_n into
// integer sample delays d with d_{n+1}^2 = d_n^2 + K_n for both array halves.
// The square root is tracked incrementally: each lane keeps a residual r with
// d^2 + r/2^F equal to the exact value. In each ITER cycle a lane moves d by at
// most one, so no multiplier is needed.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for initiate, reference delay latched on initiate
// S_LOAD    | seed both lanes with delay_0, clear residuals and flags
// S_OUT     | delay pair valid, waiting for delay_ack
// S_WAIT_TERM | waiting for term_ready, term pair latched on accept
// S_ACCUM   | add latched terms into the lane residuals
// S_ITER    | one square-root step per lane per cycle until both settle
module element_delay_tracker #(
    parameter int DW_INTEGER  = 18,
    parameter int DW_FRACTION = 6,
    parameter int DW_DELAY    = 13,
    parameter int N_TERMS     = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       initiate,
    input  logic [DW_DELAY-1:0]                        delay_0,
    input  logic signed [DW_INTEGER+DW_FRACTION:0]     term_pos_n,
    input  logic signed [DW_INTEGER+DW_FRACTION:0]     term_neg_n,
    input  logic                                       term_ready,
    output logic                                       term_ack,
    output logic [DW_DELAY-1:0]                        delay_pos,
    output logic [DW_DELAY-1:0]                        delay_neg,
    output logic [5:0]                                 element_idx,
    output logic                                       delay_valid,
    input  logic                                       delay_ack,
    output logic                                       underflow,
    output logic                                       overflow,
    output logic                                       done
);

    localparam int TW = DW_INTEGER + DW_FRACTION + 1;
    localparam int RW = DW_INTEGER + DW_FRACTION + 3;
    localparam logic [DW_DELAY-1:0]  D_MAX    = '1;
    localparam logic [5:0]           IDX_LAST = 6'(N_TERMS);
    // (2d+1)<<F minus (2d-1)<<F
    localparam logic signed [RW-1:0] TWO_F    = RW'(2) << DW_FRACTION;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OUT,
        S_WAIT_TERM,
        S_ACCUM,
        S_ITER
    } state_t;

    state_t state_q, state_nxt;

    logic [DW_DELAY-1:0]  delay_ref_q;
    logic [DW_DELAY-1:0]  d_q     [2];
    logic signed [RW-1:0] r_q     [2];
    logic signed [TW-1:0] term_q  [2];

    logic [DW_DELAY-1:0]  d_nxt   [2];
    logic signed [RW-1:0] r_nxt   [2];
    logic signed [RW-1:0] step_up [2];
    logic signed [RW-1:0] step_dn [2];
    logic [1:0]           settled;
    logic [1:0]           uf_set;
    logic [1:0]           of_set;
    logic                 last_ack;

    assign delay_pos = d_q[0];
    assign delay_neg = d_q[1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt   = state_q;
        term_ack    = 1'b0;
        delay_valid = 1'b0;
        last_ack    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (initiate) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                delay_valid = 1'b1;
                if (delay_ack) begin
                    if (element_idx == IDX_LAST) begin
                        last_ack  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT_TERM;
                    end
                end
            end
            S_WAIT_TERM: begin
                if (term_ready) begin
                    term_ack  = 1'b1;
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                state_nxt = S_ITER;
            end
            S_ITER: begin
                if (settled == 2'b11) state_nxt = S_OUT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One square-root step per lane; clamps count as the settling step
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            step_up[i] = RW'({d_q[i], 1'b1}) << DW_FRACTION;
            step_dn[i] = step_up[i] - TWO_F;
            d_nxt[i]   = d_q[i];
            r_nxt[i]   = r_q[i];
            settled[i] = 1'b0;
            uf_set[i]  = 1'b0;
            of_set[i]  = 1'b0;
            if (r_q[i] >= step_up[i]) begin
                if (d_q[i] == D_MAX) begin
                    r_nxt[i]   = '0;
                    of_set[i]  = 1'b1;
                    settled[i] = 1'b1;
                end else begin
                    r_nxt[i] = r_q[i] - step_up[i];
                    d_nxt[i] = d_q[i] + DW_DELAY'(1);
                end
            end else if (r_q[i][RW-1]) begin
                if (d_q[i] != '0) begin
                    r_nxt[i] = r_q[i] + step_dn[i];
                    d_nxt[i] = d_q[i] - DW_DELAY'(1);
                end else begin
                    r_nxt[i]   = '0;
                    uf_set[i]  = 1'b1;
                    settled[i] = 1'b1;
                end
            end else begin
                settled[i] = 1'b1;
            end
        end
    end

    // Lane datapath, element counter, sticky flags and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_ref_q <= '0;
            element_idx <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                d_q[i]    <= '0;
                r_q[i]    <= '0;
                term_q[i] <= '0;
            end
        end else begin
            done <= last_ack;
            case (state_q)
                S_IDLE: begin
                    if (initiate) delay_ref_q <= delay_0;
                end
                S_LOAD: begin
                    element_idx <= '0;
                    underflow   <= 1'b0;
                    overflow    <= 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        d_q[i] <= delay_ref_q;
                        r_q[i] <= '0;
                    end
                end
                S_WAIT_TERM: begin
                    if (term_ready) begin
                        term_q[0] <= term_pos_n;
                        term_q[1] <= term_neg_n;
                    end
                end
                S_ACCUM: begin
                    for (int i = 0; i < 2; i++) begin
                        r_q[i] <= r_q[i] + {{(RW-TW){term_q[i][TW-1]}}, term_q[i]};
                    end
                end
                S_ITER: begin
                    for (int i = 0; i < 2; i++) begin
                        d_q[i] <= d_nxt[i];
                        r_q[i] <= r_nxt[i];
                    end
                    if (uf_set != 2'b00) underflow <= 1'b1;
                    if (of_set != 2'b00) overflow  <= 1'b1;
                    if (settled == 2'b11) element_idx <= element_idx + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_element_delay_tracker.sv
// Bench for element_delay_tracker. The reference keeps the exact value
// d^2 + r in 64ths per lane and recovers d with an integer square root.
module tb_element_delay_tracker;

    localparam int     N_TERMS = 32;
    localparam longint D_MAX   = 8191;

    logic               clk;
    logic               rst;
    logic               initiate;
    logic [12:0]        delay_0;
    logic signed [24:0] term_pos_n;
    logic signed [24:0] term_neg_n;
    logic               term_ready;
    logic               term_ack;
    logic [12:0]        delay_pos;
    logic [12:0]        delay_neg;
    logic [5:0]         element_idx;
    logic               delay_valid;
    logic               delay_ack;
    logic               underflow;
    logic               overflow;
    logic               done;

    int checks   = 0;
    int failures = 0;
    int pos_terms [N_TERMS];
    int neg_terms [N_TERMS];

    element_delay_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .initiate    (initiate),
        .delay_0     (delay_0),
        .term_pos_n  (term_pos_n),
        .term_neg_n  (term_neg_n),
        .term_ready  (term_ready),
        .term_ack    (term_ack),
        .delay_pos   (delay_pos),
        .delay_neg   (delay_neg),
        .element_idx (element_idx),
        .delay_valid (delay_valid),
        .delay_ack   (delay_ack),
        .underflow   (underflow),
        .overflow    (overflow),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // largest d with d*d*64 <= s
    function automatic longint isqrt64(input longint s);
        longint d;
        d = longint'($sqrt(real'(s) / 64.0));
        while (d > 0 && d * d * 64 > s) d--;
        while ((d + 1) * (d + 1) * 64 <= s) d++;
        return d;
    endfunction

    function automatic int rand_term();
        return int'($urandom_range(0, 80000)) - 40000;
    endfunction

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b1;
        while (delay_valid !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_TERMS; i++) begin
            pos_terms[i] = rand_term();
            neg_terms[i] = rand_term();
        end
    endtask

    task automatic run_calc(input int d0, input int ack_stall, input int rdy_stall);
        longint s [2];
        longint exp_d [2];
        longint old_d;
        longint dd;
        longint term;
        bit     uf;
        bit     of;
        int     cyc;
        bit     ok;
        int     steps;
        int     stall;
        bit     stable;
        bit     spur;

        @(negedge clk);
        delay_0  = 13'(d0);
        initiate = 1'b1;
        @(negedge clk);
        initiate = 1'b0;
        delay_0  = '0;

        s[0] = longint'(d0) * longint'(d0) * 64;
        s[1] = s[0];
        exp_d[0] = longint'(d0);
        exp_d[1] = longint'(d0);
        uf = 1'b0;
        of = 1'b0;
        steps = 0;

        for (int n = 0; n <= N_TERMS; n++) begin
            wait_valid(cyc, ok);
            if (!ok) begin
                check_val("valid_timeout", 0, 1);
                finish_run();
            end
            if (n == 0) check_val("load_latency", cyc, 1);
            else        check_val("iter_latency", cyc + 2, steps + 3);
            check_val("element_idx", element_idx, n);
            check_val("delay_pos", delay_pos, exp_d[0]);
            check_val("delay_neg", delay_neg, exp_d[1]);
            check_val("underflow", underflow, uf);
            check_val("overflow", overflow, of);

            // hold off the ack; term_ready and initiate must be ignored here
            stall  = int'($urandom_range(0, ack_stall));
            stable = 1'b1;
            spur   = 1'b0;
            for (int k = 0; k < stall; k++) begin
                term_ready = 1'b1;
                initiate   = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (delay_valid !== 1'b1 || delay_pos !== 13'(exp_d[0]) ||
                    delay_neg !== 13'(exp_d[1]) || element_idx !== 6'(n))
                    stable = 1'b0;
                if (term_ack !== 1'b0) spur = 1'b1;
            end
            term_ready = 1'b0;
            initiate   = 1'b0;
            if (stall > 0) begin
                check_val("hold_stable", stable, 1);
                check_val("no_ack_in_out", spur, 0);
            end

            delay_ack = 1'b1;
            @(negedge clk);
            delay_ack = 1'b0;
            check_val("valid_drop", delay_valid, 0);
            check_val("done", done, (n == N_TERMS) ? 1 : 0);

            if (n == N_TERMS) begin
                @(negedge clk);
                check_val("done_pulse", done, 0);
            end else begin
                stall = int'($urandom_range(0, rdy_stall));
                spur  = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    delay_ack = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (term_ack !== 1'b0 || delay_valid !== 1'b0) spur = 1'b1;
                end
                delay_ack = 1'b0;
                if (stall > 0) check_val("idle_wait_term", spur, 0);

                term_pos_n = 25'(pos_terms[n]);
                term_neg_n = 25'(neg_terms[n]);
                term_ready = 1'b1;
                #1;
                check_val("term_ack", term_ack, 1);
                @(negedge clk);
                // keep ready high with junk terms: must not be taken again
                term_pos_n = 25'($urandom);
                term_neg_n = 25'($urandom);
                #1;
                check_val("term_ack_single", term_ack, 0);
                @(negedge clk);
                term_ready = 1'b0;

                steps = 0;
                for (int i = 0; i < 2; i++) begin
                    old_d = exp_d[i];
                    term  = (i == 0) ? longint'(pos_terms[n]) : longint'(neg_terms[n]);
                    s[i]  = s[i] + term;
                    if (s[i] < 0) begin
                        s[i]     = 0;
                        exp_d[i] = 0;
                        uf       = 1'b1;
                    end else begin
                        exp_d[i] = isqrt64(s[i]);
                        if (exp_d[i] > D_MAX) begin
                            exp_d[i] = D_MAX;
                            s[i]     = D_MAX * D_MAX * 64;
                            of       = 1'b1;
                        end
                    end
                    dd = (exp_d[i] > old_d) ? exp_d[i] - old_d : old_d - exp_d[i];
                    if (int'(dd) > steps) steps = int'(dd);
                end
            end
        end
    endtask

    task automatic reset_mid_iter();
        int  cyc;
        bit  ok;
        bit  spur;

        @(negedge clk);
        delay_0  = '0;
        initiate = 1'b1;
        @(negedge clk);
        initiate = 1'b0;
        wait_valid(cyc, ok);
        if (!ok) begin
            check_val("valid_timeout", 0, 1);
            finish_run();
        end
        delay_ack = 1'b1;
        @(negedge clk);
        delay_ack  = 1'b0;
        term_pos_n = 25'(1 << 20);
        term_neg_n = 25'(1 << 20);
        term_ready = 1'b1;
        @(negedge clk);
        term_ready = 1'b0;
        repeat (20) @(negedge clk);
        check_val("mid_iter", (delay_pos != 0 && delay_valid == 1'b0) ? 1 : 0, 1);

        #2 rst = 1'b0;
        #1;
        check_val("rst_delay_pos", delay_pos, 0);
        check_val("rst_delay_neg", delay_neg, 0);
        check_val("rst_idx", element_idx, 0);
        check_val("rst_valid", delay_valid, 0);
        check_val("rst_flags", {underflow, overflow, done, term_ack}, 0);
        @(negedge clk);
        rst = 1'b1;

        term_ready = 1'b1;
        delay_ack  = 1'b1;
        spur       = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (term_ack !== 1'b0 || done !== 1'b0 || delay_valid !== 1'b0) spur = 1'b1;
        end
        term_ready = 1'b0;
        delay_ack  = 1'b0;
        check_val("idle_after_reset", spur, 0);
    endtask

    initial begin
        rst        = 1'b0;
        initiate   = 1'b0;
        delay_0    = '0;
        term_pos_n = '0;
        term_neg_n = '0;
        term_ready = 1'b0;
        delay_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_valid", delay_valid, 0);
        check_val("reset_outputs", {delay_pos, delay_neg, element_idx}, 0);
        check_val("reset_flags", {underflow, overflow, done, term_ack}, 0);
        rst = 1'b1;
        @(negedge clk);

        // constant growth from zero: element 1 lands on 4/4
        for (int i = 0; i < N_TERMS; i++) begin
            pos_terms[i] = 1054;
            neg_terms[i] = 1054;
        end
        run_calc(0, 0, 0);

        // decrement on one side, increment on the other, with stalls
        fill_random();
        pos_terms[0] = -1280;
        neg_terms[0] = 1280;
        run_calc(10, 5, 7);

        // d_n^2 = 200^2 + 16.46875*n^2
        for (int i = 0; i < N_TERMS; i++) begin
            pos_terms[i] = 1054 * (2 * i + 1);
            neg_terms[i] = 1054 * (2 * i + 1);
        end
        run_calc(200, 3, 3);

        // underflow on the positive side
        fill_random();
        pos_terms[0] = -640;
        run_calc(1, 2, 2);

        // overflow at the top of the range, flags must clear on next start
        fill_random();
        pos_terms[0] = 1 << 22;
        neg_terms[0] = 1 << 22;
        run_calc(8190, 2, 2);

        fill_random();
        run_calc(int'($urandom_range(0, 4000)), 4, 4);

        reset_mid_iter();

        fill_random();
        run_calc(int'($urandom_range(0, 300)), 6, 6);

        finish_run();
    end

endmodule
